// File: rtl/semaforo_param.sv
// Parametrised two-way traffic-light controller. Road A is main, road B is secondary.
// Phase sequence A_GREEN -> A_YELLOW -> CLR_AB -> B_GREEN -> B_YELLOW -> CLR_BA.
module semaforo_param #(
    parameter int unsigned W          = 8,
    parameter int unsigned T_VERDE    = 4,
    parameter int unsigned T_AMARELO  = 2,
    parameter int unsigned T_VERMELHO = 3,
    parameter int unsigned T_LIMPEZA  = 1,
    parameter int unsigned MODO_BOTAO = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       req_pend,
    output logic [2:0] fase
);

    typedef enum logic [2:0] {
        AGreen  = 3'd0,
        AYellow = 3'd1,
        ClrAb   = 3'd2,
        BGreen  = 3'd3,
        BYellow = 3'd4,
        ClrBa   = 3'd5
    } fase_e;

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    // Terminal counter values: a phase of duration T exits when the counter reaches T-1.
    localparam logic [W-1:0] LastVerde    = W'(T_VERDE - 1);
    localparam logic [W-1:0] LastAmarelo  = W'(T_AMARELO - 1);
    localparam logic [W-1:0] LastVermelho = W'(T_VERMELHO - 1);
    localparam logic [W-1:0] LastLimpeza  = W'(T_LIMPEZA - 1);

    fase_e        fase_q, fase_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         req_q, req_d;

    always_comb begin
        fase_d = fase_q;
        cnt_d  = cnt_q + 1'b1;
        case (fase_q)
            AGreen: begin
                if (MODO_BOTAO != 0) begin
                    if (cnt_q >= LastVerde && req_q) begin
                        fase_d = AYellow;
                        cnt_d  = '0;
                    end else if (cnt_q >= LastVerde) begin
                        // Hold at the minimum-green point until a request arrives.
                        cnt_d = LastVerde;
                    end
                end else if (cnt_q == LastVerde) begin
                    fase_d = AYellow;
                    cnt_d  = '0;
                end
            end
            AYellow: begin
                if (cnt_q == LastAmarelo) begin
                    fase_d = ClrAb;
                    cnt_d  = '0;
                end
            end
            ClrAb: begin
                if (cnt_q == LastLimpeza) begin
                    fase_d = BGreen;
                    cnt_d  = '0;
                end
            end
            BGreen: begin
                if (cnt_q == LastVermelho) begin
                    fase_d = BYellow;
                    cnt_d  = '0;
                end
            end
            BYellow: begin
                if (cnt_q == LastAmarelo) begin
                    fase_d = ClrBa;
                    cnt_d  = '0;
                end
            end
            ClrBa: begin
                if (cnt_q == LastLimpeza) begin
                    fase_d = AGreen;
                    cnt_d  = '0;
                end
            end
            default: begin
                fase_d = AGreen;
                cnt_d  = '0;
            end
        endcase

        // Entering B green serves the request; the clear beats a simultaneous press.
        req_d = req_q;
        if (fase_d == BGreen && fase_q != BGreen) begin
            req_d = 1'b0;
        end else if (bt && fase_q != BGreen) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fase_q <= AGreen;
            cnt_q  <= '0;
            req_q  <= 1'b0;
        end else begin
            fase_q <= fase_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
        end
    end

    // Lamps depend on the phase register only; unknown codes show red both ways.
    always_comb begin
        A = LampRed;
        B = LampRed;
        case (fase_q)
            AGreen:  A = LampGreen;
            AYellow: A = LampYellow;
            BGreen:  B = LampGreen;
            BYellow: B = LampYellow;
            default: begin
                A = LampRed;
                B = LampRed;
            end
        endcase
    end

    assign fase     = fase_q;
    assign req_pend = req_q;

endmodule

// File: tb/tb_semaforo_param.sv
// Bench for semaforo_param: button-mode and free-running instances share stimulus,
// a phase/elapsed-time reference model feeds a scoreboard checked on the falling edge.
module tb_semaforo_param;

    localparam int T_VERDE    = 4;
    localparam int T_AMARELO  = 2;
    localparam int T_VERMELHO = 3;
    localparam int T_LIMPEZA  = 1;

    typedef struct {
        int fase;
        int a;
        int b;
        int rp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic bt;
    logic [2:0] a1, b1, f1, a0, b0, f0;
    logic r1, r0;

    int tests = 0;
    int fails = 0;

    int   ph[2];
    int   el[2];
    bit   pend[2];
    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    semaforo_param #(.MODO_BOTAO(1)) u_btn (
        .clk(clk), .rst(rst), .bt(bt), .A(a1), .B(b1), .req_pend(r1), .fase(f1)
    );

    semaforo_param #(.MODO_BOTAO(0)) u_free (
        .clk(clk), .rst(rst), .bt(bt), .A(a0), .B(b0), .req_pend(r0), .fase(f0)
    );

    function automatic int dur(input int p);
        case (p)
            0:       return T_VERDE;
            1, 4:    return T_AMARELO;
            3:       return T_VERMELHO;
            default: return T_LIMPEZA;
        endcase
    endfunction

    function automatic int lamp_a(input int p);
        return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    endfunction

    function automatic int lamp_b(input int p);
        return (p == 3) ? 1 : (p == 4) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ph[m]   = 0;
            el[m]   = 0;
            pend[m] = 1'b0;
        end
        q1.delete();
        q0.delete();
    endtask

    task automatic model_edge(input int m, input bit b);
        bit   leave;
        int   np;
        exp_t e;
        if (ph[m] == 0 && m == 1) leave = (el[m] + 1 >= T_VERDE) && pend[m];
        else                      leave = (el[m] + 1 >= dur(ph[m]));
        np = leave ? (ph[m] + 1) % 6 : ph[m];
        if (np == 3 && ph[m] != 3)  pend[m] = 1'b0;
        else if (b && ph[m] != 3)   pend[m] = 1'b1;
        el[m] = leave ? 0 : el[m] + 1;
        ph[m] = np;
        e.fase = np;
        e.a    = lamp_a(np);
        e.b    = lamp_b(np);
        e.rp   = int'(pend[m]);
        if (m == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic step(input bit v);
        #2 bt = v;
        @(posedge clk);
        model_edge(1, v);
        model_edge(0, v);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_A"}, int'(a1), 1);
        chk({name, "_B"}, int'(b1), 4);
        chk({name, "_fase"}, int'(f1), 0);
        chk({name, "_req"}, int'(r1), 0);
        chk({name, "_free_A"}, int'(a0), 1);
        chk({name, "_free_B"}, int'(b0), 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 bt = 1'b0;
        rst = 1'b1;
        #1 chk_reset_outputs("rst_hold");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1 chk_reset_outputs("rst_release");
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (ph[1] != target && n < 100) begin
            step(1'b0);
            n++;
        end
        if (ph[1] != target) chk("run_until_timeout", ph[1], target);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("btn_fase", int'(f1), e.fase);
                chk("btn_A", int'(a1), e.a);
                chk("btn_B", int'(b1), e.b);
                chk("btn_req", int'(r1), e.rp);
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("free_fase", int'(f0), e.fase);
                chk("free_A", int'(a0), e.a);
                chk("free_B", int'(b0), e.b);
                chk("free_req", int'(r0), e.rp);
            end
        end
        chk("btn_safety", int'(a1 != 3'b100 && b1 != 3'b100), 0);
        chk("free_safety", int'(a0 != 3'b100 && b0 != 3'b100), 0);
    end

    initial begin
        int exp_f[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
        int exp_r[14] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        int pat[13]   = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5};
        int n;
        rst = 1'b1;
        bt  = 1'b0;
        model_reset();

        // Reset and idle: A green holds with no request
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b0);
            #1 chk("idle_fase", int'(f1), 0);
        end

        // Single press at cycle 0
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            step(k == 1);
            #1 chk("press_fase", int'(f1), exp_f[k]);
            chk("press_req", int'(r1), exp_r[k]);
        end

        // Late press: latched at edge 10, A yellow on edge 11
        do_reset();
        repeat (9) step(1'b0);
        step(1'b1);
        #1 chk("late_req", int'(r1), 1);
        chk("late_still_green", int'(f1), 0);
        step(1'b0);
        #1 chk("late_yellow", int'(f1), 1);

        // Press during B green is ignored
        run_until(3);
        step(1'b1);
        #1 chk("bgreen_press_req", int'(r1), 0);
        run_until(0);
        repeat (10) step(1'b0);
        #1 chk("bgreen_press_hold", int'(f1), 0);

        // Press during B yellow latches; next A green lasts exactly T_VERDE cycles
        step(1'b1);
        run_until(4);
        step(1'b1);
        #1 chk("byellow_req", int'(r1), 1);
        run_until(0);
        n = 0;
        do begin
            step(1'b0);
            #1 n++;
        end while (f1 == 3'd0 && n < 50);
        chk("a_green_len", n, T_VERDE);

        // Free-running: 13-cycle pattern repeats three times regardless of bt
        do_reset();
        for (int k = 1; k <= 39; k++) begin
            step(1'($urandom_range(0, 1)));
            #1 chk("free_pattern", int'(f0), pat[k % 13]);
        end

        // Asynchronous reset in the middle of B green
        do_reset();
        step(1'b1);
        run_until(3);
        step(1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        // Random traffic
        repeat (800) step(1'($urandom_range(0, 7) == 0));
        repeat (200) step(1'($urandom_range(0, 1)));

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
